// File: rtl/pipelined_barrel_rotator_left.sv
// Pipelined left barrel rotator with valid/ready handshakes; stage k applies the 2^k rotation step.
// Optional input capture register: define PIPELINED_BARREL_ROTATOR_LEFT_INPUT_REGISTER_EN.
module pipelined_barrel_rotator_left #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROTATION_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [ROTATION_WIDTH-1:0] rotation,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int LAST = ROTATION_WIDTH - 1;

    function automatic logic [DATA_WIDTH-1:0] rotl_by(input logic [DATA_WIDTH-1:0] d,
                                                      input int amt);
        return (d << amt) | (d >> (DATA_WIDTH - amt));
    endfunction

    // Step 2^k reduced mod the width so non-power-of-two widths wrap instead of zeroing.
    function automatic int step_amount(input int k);
        return (1 << k) % DATA_WIDTH;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] stage_rotate(input logic [DATA_WIDTH-1:0] d,
                                                           input logic sel,
                                                           input int k);
        return sel ? rotl_by(d, step_amount(k)) : d;
    endfunction

    logic                      src_vld;
    logic [DATA_WIDTH-1:0]     src_data;
    logic [ROTATION_WIDTH-1:0] src_rot;

    logic [ROTATION_WIDTH-1:0] vld_p;
    logic [ROTATION_WIDTH-1:0] adv_p;
    logic [DATA_WIDTH-1:0]     data_p [ROTATION_WIDTH];
    logic [ROTATION_WIDTH-1:0] rot_p  [ROTATION_WIDTH];

    logic [ROTATION_WIDTH-1:0] pred_vld;
    logic [DATA_WIDTH-1:0]     pred_data [ROTATION_WIDTH];
    logic [ROTATION_WIDTH-1:0] pred_rot  [ROTATION_WIDTH];

`ifdef PIPELINED_BARREL_ROTATOR_LEFT_INPUT_REGISTER_EN
    // ---- input capture stage: isolates data_in/rotation timing from the first rotate step ----
    logic                      in_vld_p;
    logic [DATA_WIDTH-1:0]     in_data_p;
    logic [ROTATION_WIDTH-1:0] in_rot_p;
    logic                      in_adv;

    assign in_adv   = !in_vld_p || adv_p[0];
    assign in_ready = in_adv;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_vld_p  <= 1'b0;
            in_data_p <= '0;
            in_rot_p  <= '0;
        end else if (in_adv) begin
            in_vld_p <= in_valid;
            if (in_valid) begin
                in_data_p <= data_in;
                in_rot_p  <= rotation;
            end
        end
    end

    assign src_vld  = in_vld_p;
    assign src_data = in_data_p;
    assign src_rot  = in_rot_p;
`else
    assign src_vld  = in_valid;
    assign src_data = data_in;
    assign src_rot  = rotation;
    assign in_ready = adv_p[0];
`endif

    // Stage k may advance when it, or any stage after it, has room; unrolled to avoid a comb loop.
    always_comb begin
        logic acc;
        acc   = out_ready;
        adv_p = '0;
        for (int k = LAST; k >= 0; k--) begin
            acc      = acc | ~vld_p[k];
            adv_p[k] = acc;
        end
    end

    always_comb begin
        pred_vld     = '0;
        pred_data    = '{default: '0};
        pred_rot     = '{default: '0};
        pred_vld[0]  = src_vld;
        pred_data[0] = src_data;
        pred_rot[0]  = src_rot;
        for (int k = 1; k < ROTATION_WIDTH; k++) begin
            pred_vld[k]  = vld_p[k-1];
            pred_data[k] = data_p[k-1];
            pred_rot[k]  = rot_p[k-1];
        end
    end

    // ---- rotate stages: each consumes bit 0 of the remaining amount and shifts the rest down ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < ROTATION_WIDTH; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
                rot_p[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < ROTATION_WIDTH; k++) begin
                if (adv_p[k]) begin
                    vld_p[k] <= pred_vld[k];
                    if (pred_vld[k]) begin
                        data_p[k] <= stage_rotate(pred_data[k], pred_rot[k][0], k);
                        rot_p[k]  <= pred_rot[k] >> 1;
                    end
                end
            end
        end
    end

    // ---- output: last stage drives the downstream handshake ----
    assign out_valid = vld_p[LAST];
    assign data_out  = data_p[LAST];

endmodule

// File: tb/tb_pipelined_barrel_rotator_left.sv
// Scoreboard bench for pipelined_barrel_rotator_left: 8-bit and 6-bit instances.
module tb_pipelined_barrel_rotator_left;

    localparam int RW = 3;
`ifdef PIPELINED_BARREL_ROTATOR_LEFT_INPUT_REGISTER_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int CAP = RW + EXTRA;
    localparam int LAT = RW + EXTRA;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] d8_data_in;
    logic [2:0] d8_rot;
    logic       d8_in_valid;
    logic       d8_in_ready;
    logic [7:0] d8_data_out;
    logic       d8_out_valid;
    logic       d8_out_ready = 1'b1;
    logic [5:0] d6_data_in;
    logic [2:0] d6_rot;
    logic       d6_in_valid;
    logic       d6_in_ready;
    logic [5:0] d6_data_out;
    logic       d6_out_valid;
    logic       d6_out_ready;

    pipelined_barrel_rotator_left #(.DATA_WIDTH(8), .ROTATION_WIDTH(3)) dut8 (
        .clock(clock), .resetn(resetn), .data_in(d8_data_in), .rotation(d8_rot),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .data_out(d8_data_out),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready));

    pipelined_barrel_rotator_left #(.DATA_WIDTH(6), .ROTATION_WIDTH(3)) dut6 (
        .clock(clock), .resetn(resetn), .data_in(d6_data_in), .rotation(d6_rot),
        .in_valid(d6_in_valid), .in_ready(d6_in_ready), .data_out(d6_data_out),
        .out_valid(d6_out_valid), .out_ready(d6_out_ready));

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ready_mode = 1;
    bit lat_mode = 0;
    bit stream_mode = 0;
    int s_cnt = 0;
    int gaps = 0;
    int n_in8 = 0;
    int n_out8 = 0;
    logic [7:0] exp8 = '0;
    logic [5:0] exp6 = '0;
    logic [7:0] q8[$];
    int         qc8[$];
    logic [5:0] q6[$];
    int         qc6[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] d, input int r);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) res[(i + r) % 8] = d[i];
        return res;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       d8_out_ready = 1'b0;
            1:       d8_out_ready = 1'b1;
            default: d8_out_ready = ($urandom_range(0, 99) < 65);
        endcase
    end

    logic [7:0] m8_e;
    int         m8_c;
    bit         stall8 = 0;
    logic [7:0] prev8 = '0;

    always @(negedge clock) begin
        if (!resetn) begin
            stall8 = 0;
        end else begin
            if (stall8) begin
                check_eq("stall_out_valid", 32'(d8_out_valid), 32'd1);
                check_eq("stall_data_out", 32'(d8_data_out), 32'(prev8));
            end
            if (d8_out_valid && d8_out_ready) begin
                n_out8++;
                if (stream_mode) s_cnt++;
                if (q8.size() == 0) begin
                    check_eq("out_with_empty_queue", 32'(d8_out_valid), 32'd0);
                end else begin
                    m8_e = q8.pop_front();
                    m8_c = qc8.pop_front();
                    check_eq("data8", 32'(d8_data_out), 32'(m8_e));
                    if (lat_mode) check_eq("latency8", cyc - m8_c, LAT);
                end
            end else if (stream_mode && s_cnt > 0 && s_cnt < 256 && !d8_out_valid) begin
                gaps++;
            end
            if (d8_in_valid && d8_in_ready) begin
                q8.push_back(exp8);
                qc8.push_back(cyc);
                n_in8++;
            end
            stall8 = d8_out_valid && !d8_out_ready;
            prev8  = d8_data_out;
        end
    end

    logic [5:0] m6_e;
    int         m6_c;

    always @(negedge clock) begin
        if (resetn) begin
            if (d6_out_valid && d6_out_ready) begin
                if (q6.size() == 0) begin
                    check_eq("out6_with_empty_queue", 32'(d6_out_valid), 32'd0);
                end else begin
                    m6_e = q6.pop_front();
                    m6_c = qc6.pop_front();
                    check_eq("data6", 32'(d6_data_out), 32'(m6_e));
                    if (lat_mode) check_eq("latency6", cyc - m6_c, LAT);
                end
            end
            if (d6_in_valid && d6_in_ready) begin
                q6.push_back(exp6);
                qc6.push_back(cyc);
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] r, input logic [7:0] e,
                         input int max_cyc);
        int  n;
        bit  took;
        d8_data_in  = d;
        d8_rot      = r;
        exp8        = e;
        d8_in_valid = 1'b1;
        n    = 0;
        took = 0;
        while (!took && n < max_cyc) begin
            @(negedge clock);
            took = d8_in_ready;
            @(posedge clock);
            #1;
            n++;
        end
        d8_in_valid = 1'b0;
        if (!took) check_eq("send_accept", 32'(took), 32'd1);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q8.size() != 0 || q6.size() != 0) && n < max_cyc) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("drain_q8", q8.size(), 0);
        check_eq("drain_q6", q6.size(), 0);
    endtask

    logic [7:0] dir_d8 [4] = '{8'h81, 8'h12, 8'h5A, 8'h81};
    logic [2:0] dir_r8 [4] = '{3'd1, 3'd4, 3'd0, 3'd7};
    logic [7:0] dir_e8 [4] = '{8'h03, 8'h21, 8'h5A, 8'hC0};
    logic [5:0] dir_d6 [4] = '{6'b000001, 6'b000001, 6'b000001, 6'b100001};
    logic [2:0] dir_r6 [4] = '{3'd5, 3'd6, 3'd7, 3'd3};
    logic [5:0] dir_e6 [4] = '{6'b100000, 6'b000001, 6'b000010, 6'b001100};

    initial begin
        logic [7:0] rd;
        logic [2:0] rr;
        int idx;
        int snap;
        resetn       = 1'b0;
        d8_data_in   = '0;
        d8_rot       = '0;
        d8_in_valid  = 1'b0;
        d6_data_in   = '0;
        d6_rot       = '0;
        d6_in_valid  = 1'b0;
        d6_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_out_valid8", 32'(d8_out_valid), 32'd0);
        check_eq("rst_data_out8", 32'(d8_data_out), 32'd0);
        check_eq("rst_in_ready8", 32'(d8_in_ready), 32'd1);
        check_eq("rst_out_valid6", 32'(d6_out_valid), 32'd0);
        check_eq("rst_in_ready6", 32'(d6_in_ready), 32'd1);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Directed words, unstalled, with latency checks
        lat_mode = 1;
        for (int i = 0; i < 4; i++) begin
            d6_data_in  = dir_d6[i];
            d6_rot      = dir_r6[i];
            exp6        = dir_e6[i];
            d6_in_valid = 1'b1;
            send8(dir_d8[i], dir_r8[i], dir_e8[i], 20);
        end
        d6_in_valid = 1'b0;
        drain(50);
        lat_mode = 0;

        // Backpressure: offer 5 words with out_ready held low
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            d8_data_in  = 8'hA1 + 8'(idx);
            d8_rot      = 3'(idx + 1);
            exp8        = rotl8(d8_data_in, idx + 1);
            d8_in_valid = (idx < 5);
            @(negedge clock);
            if (d8_in_valid && d8_in_ready) idx++;
            @(posedge clock);
            #1;
        end
        d8_in_valid = 1'b0;
        check_eq("bp_accepted", idx, CAP);
        check_eq("bp_in_ready", 32'(d8_in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(d8_out_valid), 32'd1);
        ready_mode = 1;
        drain(50);

        // Streaming: back-to-back words, one per cycle
        repeat (2) @(posedge clock);
        #1;
        stream_mode = 1;
        s_cnt = 0;
        gaps  = 0;
        for (int i = 0; i < 256; i++) begin
            rd = 8'($urandom_range(0, 255));
            rr = 3'($urandom_range(0, 7));
            send8(rd, rr, rotl8(rd, int'(rr)), 1);
        end
        drain(50);
        stream_mode = 0;
        check_eq("stream_count", s_cnt, 256);
        check_eq("stream_gaps", gaps, 0);

        // Random valid/ready toggling
        ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            rd = 8'($urandom_range(0, 255));
            rr = 3'($urandom_range(0, 7));
            send8(rd, rr, rotl8(rd, int'(rr)), 1000);
        end
        ready_mode = 1;
        drain(200);
        check_eq("in_out_count", n_out8, n_in8);

        // Reset with two words in flight
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        send8(8'h3C, 3'd2, rotl8(8'h3C, 2), 20);
        send8(8'hE7, 3'd5, rotl8(8'hE7, 5), 20);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(d8_out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(d8_in_ready), 32'd1);
        check_eq("midrst_data_out", 32'(d8_data_out), 32'd0);
        q8.delete();
        qc8.delete();
        snap = n_out8;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        ready_mode = 1;
        repeat (10) @(posedge clock);
        #1;
        check_eq("post_reset_no_output", n_out8, snap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
